fp_int_weight_serializer: RTL
=============================

Name: fp_int_weight_serializer

Overview:
- Transmit-side driver for the bit-serial FP16×INT MAC.
- Accepts parallel (activation, integer weight, precision) jobs over a valid/ready handshake.
- Drives the MAC's set/act/valid/w/precision inputs: one set cycle, then the weight streamed LSB-first over `precision` cycles.
- Waits for the MAC's done before issuing the next job. A one-deep input buffer lets the next job be accepted while the current one is in flight.

Parameters:
- ACT_WIDTH, 16, activation width (FP16).
- MAX_W_BITS, 8, maximum weight precision in bits; also the weight input width.
- CNT_WIDTH, 16, width of the completed-job counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  job offered.
- in_ready  out  1  job accepted when in_valid && in_ready.
- in_act  in  ACT_WIDTH  FP16 activation.
- in_w  in  MAX_W_BITS  two's-complement weight, right-aligned to precision.
- in_precision  in  4  weight bit count for this job.
- mac_set  out  1  one-cycle activation load strobe.
- mac_act  out  ACT_WIDTH  activation to MAC.
- mac_valid  out  1  serial weight bit valid.
- mac_w  out  1  serial weight bit.
- mac_precision  out  4  effective precision of current job.
- mac_done  in  1  MAC accumulation complete.
- busy  out  1  job in SET/SHIFT/WAIT.
- jobs_done  out  CNT_WIDTH  completed-job count.
- proto_err  out  1  sticky: mac_done seen outside WAIT.

Behaviour:
- Reset (rst=0, async): FSM→IDLE, buffer empty. All outputs 0 except in_ready=1. Counter and proto_err cleared.
- A reset mid-job abandons the job; no partial bits are emitted after release.
- Buffer:
  - in_ready = !buf_full.
  - On accept, latch act, w and the effective precision. Effective precision: 0→1, >MAX_W_BITS→MAX_W_BITS, else unchanged.
  - Buffer empties in the cycle the FSM enters SET. Accept and pop in the same cycle are allowed: the old entry leaves, the new one is stored, buf_full stays 1.
- FSM:
  - IDLE: if buf_full → SET next cycle.
  - SET (1 cycle):
    - mac_set=1.
    - mac_act and mac_precision = job values, held stable until the next SET.
    - Shift register ← w; bit counter ← precision.
    - → SHIFT.
  - SHIFT:
    - mac_valid=1, mac_w = shreg[0]; shift right each cycle; counter decrements.
    - Exactly `precision` valid cycles. The MSB (sign) goes last.
    - After the last bit → WAIT.
  - WAIT:
    - mac_valid=0.
    - On mac_done=1: jobs_done increments (wraps at 2^CNT_WIDTH). Then go to SET if buf_full, else IDLE.
    - mac_done and next-job SET are never in the same cycle; SET follows in the next cycle.
- Latency: accept at cycle t → mac_set at t+2 (buffer at t+1, SET at t+2) → first weight bit at t+3 → last bit at t+2+P.
- mac_done in IDLE, SET or SHIFT: ignored for sequencing; sets proto_err (sticky until reset).
- mac_set and mac_valid are never both high.
- busy = (state != IDLE).

Decomposition:
- Shared package:
  - FSM state encoding (IDLE, SET, SHIFT, WAIT).
  - PREC_W=4 constant.
  - Precision-clamp function, reused by the MAC-side precision handling.
- One natural sub-module: fp_int_job_buffer (one-deep valid/ready register slice holding act, w and precision).
- Serializer FSM, shift register and counters stay in the top.

Test Plan:
- Reset: rst=0 mid-SHIFT → all MAC-side outputs 0 at once, in_ready=1, jobs_done=0. After release, no stray mac_valid.
- Single job: act=16'h3C00, w=4'b1011, precision=4 → mac_set at t+2. mac_w sequence 1,1,0,1 with mac_valid high 4 cycles. mac_done → jobs_done=1.
- Precision clamp:
  - precision=0 → 1 valid cycle carrying w[0].
  - precision=12 → 8 valid cycles.
  - mac_precision shows 1 and 8 respectively.
- Back-to-back: second job offered during the first job's SHIFT → accepted (in_ready=1). Third job sees in_ready=0 until the second is popped. Second mac_set comes exactly 1 cycle after the first job's mac_done.
- Protocol error: mac_done pulse during SHIFT → proto_err=1 and sticky; bit stream unaltered; jobs_done unchanged.
- Counter wrap: CNT_WIDTH=4, 17 jobs → jobs_done=1.

Source files
------------

// File: rtl/fp_int_weight_serializer_pkg.sv
// Shared types and helpers for the FP16 x INT weight serializer.
// No logic of its own: state encoding, precision width, precision clamp.
// Used by the job buffer, the serializer top and the MAC-side precision path.
package fp_int_weight_serializer_pkg;

    localparam int PREC_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SET   = 2'd1,
        ST_SHIFT = 2'd2,
        ST_WAIT  = 2'd3
    } ser_state_t;

    // A zero precision still carries one bit (the sign), and nothing wider
    // than the weight bus can be streamed.
    function automatic logic [PREC_W-1:0] clamp_prec(
        input logic [PREC_W-1:0] prec,
        input int unsigned       max_bits
    );
        logic [PREC_W-1:0] res;
        if (prec == '0) begin
            res = PREC_W'(1);
        end else if (32'(prec) > max_bits) begin
            res = PREC_W'(max_bits);
        end else begin
            res = prec;
        end
        return res;
    endfunction

endpackage

// File: rtl/fp_int_weight_serializer_if.sv
// Job-side and MAC-side signal bundle of the weight serializer.
// Pure wiring, no latency.
// Job side is valid/ready; MAC side is strobe/valid with a done return.
interface fp_int_weight_serializer_if #(
    parameter int ACT_WIDTH  = 16,
    parameter int MAX_W_BITS = 8
);
    logic                                          in_valid;
    logic                                          in_ready;
    logic [ACT_WIDTH-1:0]                          in_act;
    logic [MAX_W_BITS-1:0]                         in_w;
    logic [fp_int_weight_serializer_pkg::PREC_W-1:0] in_precision;

    logic                                          mac_set;
    logic [ACT_WIDTH-1:0]                          mac_act;
    logic                                          mac_valid;
    logic                                          mac_w;
    logic [fp_int_weight_serializer_pkg::PREC_W-1:0] mac_precision;
    logic                                          mac_done;

    // Serializer side
    modport slave (
        input  in_valid, in_act, in_w, in_precision, mac_done,
        output in_ready, mac_set, mac_act, mac_valid, mac_w, mac_precision
    );

    // Job producer / MAC side
    modport master (
        output in_valid, in_act, in_w, in_precision, mac_done,
        input  in_ready, mac_set, mac_act, mac_valid, mac_w, mac_precision
    );
endinterface

// File: rtl/fp_int_job_buffer.sv
// One-deep register slice holding a pending job (act, w, clamped precision).
// Latency: 1 cycle from accept to buf_full.
// Backpressure: in_ready is low while the slot is occupied.
module fp_int_job_buffer
    import fp_int_weight_serializer_pkg::*;
#(
    parameter int ACT_WIDTH  = 16,
    parameter int MAX_W_BITS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ACT_WIDTH-1:0]  in_act,
    input  logic [MAX_W_BITS-1:0] in_w,
    input  logic [PREC_W-1:0]     in_precision,
    input  logic                  pop,
    output logic                  buf_full,
    output logic [ACT_WIDTH-1:0]  buf_act,
    output logic [MAX_W_BITS-1:0] buf_w,
    output logic [PREC_W-1:0]     buf_prec
);

    logic accept;

    assign in_ready = !buf_full;
    assign accept   = in_valid && in_ready;

    // Slot occupancy and payload; a new job overrides a same-cycle pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_full <= 1'b0;
            buf_act  <= '0;
            buf_w    <= '0;
            buf_prec <= '0;
        end else if (accept) begin
            buf_full <= 1'b1;
            buf_act  <= in_act;
            buf_w    <= in_w;
            buf_prec <= clamp_prec(in_precision, MAX_W_BITS);
        end else if (pop) begin
            buf_full <= 1'b0;
        end
    end

endmodule

// File: rtl/fp_int_weight_serializer.sv
// Drives the bit-serial FP16 x INT MAC: one set cycle, then the weight LSB-first.
// Latency: accept at t -> mac_set at t+2 -> bits t+3 .. t+2+P, then wait for mac_done.
// Backpressure: one job buffered while another is in flight; in_ready low when full.
module fp_int_weight_serializer
    import fp_int_weight_serializer_pkg::*;
#(
    parameter int ACT_WIDTH  = 16,
    parameter int MAX_W_BITS = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    fp_int_weight_serializer_if.slave bus,
    output logic                     busy,
    output logic [CNT_WIDTH-1:0]     jobs_done,
    output logic                     proto_err
);

    ser_state_t            state, state_nxt;
    logic                  pop;
    logic                  done_ok;
    logic                  buf_full;
    logic [ACT_WIDTH-1:0]  buf_act;
    logic [MAX_W_BITS-1:0] buf_w;
    logic [PREC_W-1:0]     buf_prec;
    logic [MAX_W_BITS-1:0] shreg;
    logic [PREC_W-1:0]     bit_cnt;
    logic [ACT_WIDTH-1:0]  act_q;
    logic [PREC_W-1:0]     prec_q;

    fp_int_job_buffer #(
        .ACT_WIDTH  (ACT_WIDTH),
        .MAX_W_BITS (MAX_W_BITS)
    ) u_job_buffer (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (bus.in_valid),
        .in_ready     (bus.in_ready),
        .in_act       (bus.in_act),
        .in_w         (bus.in_w),
        .in_precision (bus.in_precision),
        .pop          (pop),
        .buf_full     (buf_full),
        .buf_act      (buf_act),
        .buf_w        (buf_w),
        .buf_prec     (buf_prec)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state; pop marks the transition into SET, when the job is loaded.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        done_ok   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (buf_full) begin
                    state_nxt = ST_SET;
                    pop       = 1'b1;
                end
            end
            ST_SET: begin
                state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (bit_cnt == PREC_W'(1)) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.mac_done) begin
                    done_ok = 1'b1;
                    if (buf_full) begin
                        state_nxt = ST_SET;
                        pop       = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Job datapath: load on entry to SET, shift one bit per SHIFT cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            act_q   <= '0;
            prec_q  <= '0;
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (pop) begin
            act_q   <= buf_act;
            prec_q  <= buf_prec;
            shreg   <= buf_w;
            bit_cnt <= buf_prec;
        end else if (state == ST_SHIFT) begin
            shreg   <= shreg >> 1;
            bit_cnt <= bit_cnt - PREC_W'(1);
        end
    end

    // Completion counter (wraps) and sticky protocol error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            jobs_done <= '0;
            proto_err <= 1'b0;
        end else begin
            if (done_ok) begin
                jobs_done <= jobs_done + CNT_WIDTH'(1);
            end
            if (bus.mac_done && (state != ST_WAIT)) begin
                proto_err <= 1'b1;
            end
        end
    end

    assign bus.mac_set       = (state == ST_SET);
    assign bus.mac_valid     = (state == ST_SHIFT);
    assign bus.mac_w         = (state == ST_SHIFT) && shreg[0];
    assign bus.mac_act       = act_q;
    assign bus.mac_precision = prec_q;
    assign busy              = (state != ST_IDLE);

endmodule
